// File: rtl/hdmi_tmds_pkg.sv
// Shared types and constants for the TMDS link scheduler.
// Holds the period-type enum, the scheduler state enum, the CTL codes and
// the delayed pixel bus carried by the look-ahead delay line.
package hdmi_tmds_pkg;

    // Period type presented to the per-lane TMDS encoders.
    typedef enum logic [1:0] {
        TMDS_CONTROL = 2'd0,
        TMDS_GUARD   = 2'd1,
        TMDS_VIDEO   = 2'd2
    } tmds_mode_t;

    // Link scheduler states.
    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_CONTROL  = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_GUARD    = 3'd3,
        ST_VIDEO    = 3'd4
    } sched_state_t;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
    localparam logic [3:0] CTL_IDLE           = 4'b0000;

    localparam int unsigned DEFAULT_PREAMBLE_LEN = 8;
    localparam int unsigned DEFAULT_GUARD_LEN    = 2;

    localparam int unsigned PIX_W = 24;

    // One pixel-clock sample of upstream timing and data.
    typedef struct packed {
        logic             de;
        logic             hsync;
        logic             vsync;
        logic [PIX_W-1:0] rgb;
    } pix_bus_t;

endpackage

// File: rtl/tmds_lookahead_delay.sv
// Fixed-depth shift register for the upstream {de, hsync, vsync, rgb} bus.
// Ports:
//   clk_i  - pixel clock
//   rst_ni - asynchronous active-low reset, clears every stage
//   d_i    - sample entering the line
//   q_o    - sample delayed by DEPTH cycles
module tmds_lookahead_delay
    import hdmi_tmds_pkg::*;
#(
    parameter int unsigned DEPTH = 10
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  pix_bus_t d_i,
    output pix_bus_t q_o
);

    pix_bus_t [DEPTH-1:0] sr_q;

    // Shift one stage per cycle; stage 0 takes the new sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/tmds_link_scheduler.sv
// HDMI/DVI TMDS link scheduler.
// Holds the serializers in reset until the PLL has been stable for
// RST_HOLD_CYCLES, delays the video stream by the preamble+guard look-ahead,
// and tells the lane encoders which period type to emit each pixel clock.
// Ports:
//   clk_pixel, rst_n           - pixel clock, async active-low reset
//   pll_locked                 - PLL lock, synchronous to clk_pixel
//   de_in/hsync_in/vsync_in    - upstream timing
//   rgb_in                     - upstream pixel {R,G,B}
//   serdes_rst, link_up        - serializer reset, lanes valid
//   tmds_mode, ctl             - period type and CTL3..0 for lanes 1/2
//   hsync_out/vsync_out/rgb_out- look-ahead delayed timing and pixel
//   err_short_blank            - sticky: line started without room for preamble
module tmds_link_scheduler
    import hdmi_tmds_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN    = DEFAULT_PREAMBLE_LEN,
    parameter int unsigned GUARD_LEN       = DEFAULT_GUARD_LEN,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter bit          HDMI_MODE       = 1'b1
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] rgb_in,
    output logic        serdes_rst,
    output logic        link_up,
    output logic [1:0]  tmds_mode,
    output logic [3:0]  ctl,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [23:0] rgb_out,
    output logic        err_short_blank
);

    localparam int unsigned LA      = PREAMBLE_LEN + GUARD_LEN;
    localparam int unsigned CNT_MAX0 = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int unsigned CNT_MAX = (CNT_MAX0 > RST_HOLD_CYCLES) ? CNT_MAX0 : RST_HOLD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             serdes_rst_q, serdes_rst_d;
    logic             err_q, err_d;
    logic             link_up_q, link_up_d;
    tmds_mode_t       mode_q, mode_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             de_prev_q;
    logic             de_d_q;

    pix_bus_t dl_in, dl_out;
    logic     de_rise, qual_rise;

    assign dl_in = {de_in, hsync_in, vsync_in, rgb_in};

    tmds_lookahead_delay #(
        .DEPTH (LA)
    ) u_delay (
        .clk_i  (clk_pixel),
        .rst_ni (rst_n),
        .d_i    (dl_in),
        .q_o    (dl_out)
    );

    assign de_rise   = de_in && !de_prev_q;
    // A line only gets a preamble if the previous one has fully drained.
    assign qual_rise = HDMI_MODE && (state_q == ST_CONTROL) && de_rise && !de_d_q;

    // State, counter and registered outputs.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RST_HOLD;
            cnt_q        <= '0;
            serdes_rst_q <= 1'b1;
            err_q        <= 1'b0;
            link_up_q    <= 1'b0;
            mode_q       <= TMDS_CONTROL;
            ctl_q        <= CTL_IDLE;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            rgb_q        <= '0;
            de_prev_q    <= 1'b0;
            de_d_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            serdes_rst_q <= serdes_rst_d;
            err_q        <= err_d;
            link_up_q    <= link_up_d;
            mode_q       <= mode_d;
            ctl_q        <= ctl_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
            de_prev_q    <= de_in;
            de_d_q       <= dl_out.de;
        end
    end

    // Next state, counter, serializer reset and error flag.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        serdes_rst_d = serdes_rst_q;
        err_d        = err_q;
        unique case (state_q)
            ST_RST_HOLD: begin
                serdes_rst_d = 1'b1;
                if (!serdes_rst_q) begin
                    // serdes_rst dropped last cycle; lanes start now.
                    serdes_rst_d = 1'b0;
                    state_d      = ST_CONTROL;
                end else if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    serdes_rst_d = 1'b0;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CONTROL: begin
                if (qual_rise) begin
                    state_d = ST_PREAMBLE;
                    cnt_d   = '0;
                end
            end
            ST_PREAMBLE: begin
                if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                    state_d = dl_out.de ? ST_VIDEO : ST_CONTROL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_VIDEO: begin
                if (!dl_out.de) begin
                    state_d = ST_CONTROL;
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
                cnt_d   = '0;
            end
        endcase
        if (!pll_locked) begin
            state_d      = ST_RST_HOLD;
            cnt_d        = '0;
            serdes_rst_d = 1'b1;
        end
        if (HDMI_MODE && (state_q != ST_RST_HOLD) && de_rise && !qual_rise) begin
            err_d = 1'b1;
        end
    end

    // Registered lane outputs derived from the state being entered.
    always_comb begin
        link_up_d = 1'b0;
        mode_d    = TMDS_CONTROL;
        ctl_d     = CTL_IDLE;
        hsync_d   = 1'b0;
        vsync_d   = 1'b0;
        rgb_d     = '0;
        if (state_d != ST_RST_HOLD) begin
            link_up_d = 1'b1;
            hsync_d   = dl_out.hsync;
            vsync_d   = dl_out.vsync;
            rgb_d     = dl_out.rgb;
            unique case (state_d)
                ST_PREAMBLE: ctl_d  = CTL_VIDEO_PREAMBLE;
                ST_GUARD:    mode_d = TMDS_GUARD;
                default:     mode_d = dl_out.de ? TMDS_VIDEO : TMDS_CONTROL;
            endcase
        end
    end

    assign serdes_rst      = serdes_rst_q;
    assign link_up         = link_up_q;
    assign tmds_mode       = mode_q;
    assign ctl             = ctl_q;
    assign hsync_out       = hsync_q;
    assign vsync_out       = vsync_q;
    assign rgb_out         = rgb_q;
    assign err_short_blank = err_q;

endmodule

// File: tb/tb_tmds_link_scheduler.sv
module tb_tmds_link_scheduler;

    localparam int LA   = 10;
    localparam int PRE  = 8;
    localparam int HOLD = 16;

    logic        clk_pixel = 1'b0;
    logic        rst_n     = 1'b1;
    logic        pll_locked = 1'b0;
    logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [23:0] rgb_in = '0;

    logic        h_srst, h_link, h_hs, h_vs, h_err;
    logic [1:0]  h_mode;
    logic [3:0]  h_ctl;
    logic [23:0] h_rgb;
    logic        d_srst, d_link, d_hs, d_vs, d_err;
    logic [1:0]  d_mode;
    logic [3:0]  d_ctl;
    logic [23:0] d_rgb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_pixel = ~clk_pixel;

    tmds_link_scheduler u_hdmi (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .pll_locked(pll_locked),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .serdes_rst(h_srst), .link_up(h_link), .tmds_mode(h_mode), .ctl(h_ctl),
        .hsync_out(h_hs), .vsync_out(h_vs), .rgb_out(h_rgb), .err_short_blank(h_err)
    );

    tmds_link_scheduler #(.HDMI_MODE(1'b0)) u_dvi (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .pll_locked(pll_locked),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .serdes_rst(d_srst), .link_up(d_link), .tmds_mode(d_mode), .ctl(d_ctl),
        .hsync_out(d_hs), .vsync_out(d_vs), .rgb_out(d_rgb), .err_short_blank(d_err)
    );

    // Behavioural model state: sample history, lock run length, line starts.
    logic [26:0] m_q[$];
    int          m_cur, m_seq, m_lock;
    logic        m_prev_de, m_dd_prev, m_link_prev, m_err;
    logic        e_srst = 1'b1, e_link = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_err = 1'b0;
    logic [1:0]  e_hmode = 2'd0, e_dmode = 2'd0;
    logic [3:0]  e_ctl = 4'd0;
    logic [23:0] e_rgb = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur = 0; m_seq = -1000; m_lock = 0;
        m_prev_de = 1'b0; m_dd_prev = 1'b0; m_link_prev = 1'b0; m_err = 1'b0;
        e_srst = 1'b1; e_link = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_err = 1'b0;
        e_hmode = 2'd0; e_dmode = 2'd0; e_ctl = 4'd0; e_rgb = '0;
    endtask

    // One clock edge of the reference: outputs are what the link must show after it.
    task automatic model_step();
        logic [26:0] d;
        logic        rise, qual, in_seq;
        int          off;
        rise = de_in && !m_prev_de;
        m_q.push_back({de_in, hsync_in, vsync_in, rgb_in});
        d = '0;
        if (m_q.size() > LA) d = m_q.pop_front();
        in_seq = (m_cur - 1 >= m_seq) && (m_cur - 1 < m_seq + LA);
        qual = m_link_prev && rise && !m_dd_prev && !in_seq;
        if (qual) m_seq = m_cur;
        if (m_link_prev && rise && !qual) m_err = 1'b1;
        m_lock = pll_locked ? m_lock + 1 : 0;
        e_srst = (m_lock < HOLD);
        e_link = (m_lock > HOLD);
        e_err  = m_err;
        e_hs = 1'b0; e_vs = 1'b0; e_rgb = '0; e_hmode = 2'd0; e_dmode = 2'd0; e_ctl = 4'd0;
        if (e_link) begin
            e_hs = d[25]; e_vs = d[24]; e_rgb = d[23:0];
            e_dmode = d[26] ? 2'd2 : 2'd0;
            off = m_cur - m_seq;
            if (off >= 0 && off < PRE) e_ctl = 4'b0001;
            else if (off >= PRE && off < LA) e_hmode = 2'd1;
            else e_hmode = e_dmode;
        end
        m_link_prev = e_link;
        m_dd_prev   = d[26];
        m_prev_de   = de_in;
        m_cur++;
    endtask

    // Per-cycle comparison of both configurations against the model.
    always @(negedge clk_pixel) begin
        chk("h_serdes_rst", 32'(h_srst), 32'(e_srst));
        chk("h_link_up", 32'(h_link), 32'(e_link));
        chk("h_tmds_mode", 32'(h_mode), 32'(e_hmode));
        chk("h_ctl", 32'(h_ctl), 32'(e_ctl));
        chk("h_hsync", 32'(h_hs), 32'(e_hs));
        chk("h_vsync", 32'(h_vs), 32'(e_vs));
        chk("h_rgb", 32'(h_rgb), 32'(e_rgb));
        chk("h_err", 32'(h_err), 32'(e_err));
        chk("d_serdes_rst", 32'(d_srst), 32'(e_srst));
        chk("d_link_up", 32'(d_link), 32'(e_link));
        chk("d_tmds_mode", 32'(d_mode), 32'(e_dmode));
        chk("d_ctl", 32'(d_ctl), 32'd0);
        chk("d_rgb", 32'(d_rgb), 32'(e_rgb));
        chk("d_hsync", 32'(d_hs), 32'(e_hs));
        chk("d_err", 32'(d_err), 32'd0);
    end

    task automatic tick();
        @(posedge clk_pixel);
        if (!rst_n) model_reset();
        else model_step();
        #2;
    endtask

    task automatic rand_sync();
        hsync_in = 1'($urandom_range(0, 1));
        vsync_in = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            de_in = 1'b0; rgb_in = 24'($urandom); rand_sync();
            tick();
        end
    endtask

    // One line of act pixels and blank idle cycles; optional pinned literals
    // for a normal 1280/370 line and an optional PLL drop window.
    task automatic drive_line(input int act, input int blank, input bit pin,
                              input int drop_at, input int drop_len);
        logic [23:0] first_rgb;
        first_rgb = '0;
        for (int j = 0; j < act + blank; j++) begin
            de_in  = (j < act);
            rgb_in = 24'($urandom);
            rand_sync();
            if (j == 0) first_rgb = rgb_in;
            if (drop_at >= 0) pll_locked = !(j >= drop_at && j < drop_at + drop_len);
            tick();
            if (pin) begin
                if (j == 0 || j == 7) begin
                    chk("lit_pre_mode", 32'(h_mode), 32'd0);
                    chk("lit_pre_ctl", 32'(h_ctl), 32'd1);
                end
                if (j == 8 || j == 9) chk("lit_guard_mode", 32'(h_mode), 32'd1);
                if (j == 9) chk("lit_dvi_blank", 32'(d_mode), 32'd0);
                if (j == 10) begin
                    chk("lit_video_first", 32'(h_mode), 32'd2);
                    chk("lit_rgb_latency", 32'(h_rgb), 32'(first_rgb));
                    chk("lit_dvi_first", 32'(d_mode), 32'd2);
                    chk("lit_dvi_rgb", 32'(d_rgb), 32'(first_rgb));
                end
                if (j == 1289) begin
                    chk("lit_video_last", 32'(h_mode), 32'd2);
                    chk("lit_dvi_last", 32'(d_mode), 32'd2);
                end
                if (j == 1290) begin
                    chk("lit_blank_mode", 32'(h_mode), 32'd0);
                    chk("lit_dvi_end", 32'(d_mode), 32'd0);
                end
            end
            if (drop_at >= 0 && j == drop_at) begin
                chk("lit_drop_srst", 32'(h_srst), 32'd1);
                chk("lit_drop_link", 32'(h_link), 32'd0);
                chk("lit_drop_mode", 32'(h_mode), 32'd0);
                chk("lit_drop_rgb", 32'(h_rgb), 32'd0);
            end
        end
        pll_locked = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(); tick(); tick();
        #1 rst_n = 1'b1;

        // Lock sequence.
        idle(50);
        chk("lit_prelock_srst", 32'(h_srst), 32'd1);
        chk("lit_prelock_link", 32'(h_link), 32'd0);
        pll_locked = 1'b1;
        for (int i = 0; i < 18; i++) begin
            de_in = 1'b0; rgb_in = 24'($urandom); rand_sync();
            tick();
            if (i == 14) chk("lit_hold_srst", 32'(h_srst), 32'd1);
            if (i == 15) begin
                chk("lit_release_srst", 32'(h_srst), 32'd0);
                chk("lit_release_link", 32'(h_link), 32'd0);
                chk("lit_release_rgb", 32'(h_rgb), 32'd0);
            end
            if (i == 16) chk("lit_link_up", 32'(h_link), 32'd1);
        end
        idle(30);

        // Normal line timing.
        drive_line(1280, 370, 1'b1, -1, 0);
        chk("lit_err_clean", 32'(h_err), 32'd0);

        // Short blank between two lines.
        drive_line(1280, 4, 1'b0, -1, 0);
        chk("lit_err_before", 32'(h_err), 32'd0);
        drive_line(1280, 370, 1'b0, -1, 0);
        chk("lit_err_short", 32'(h_err), 32'd1);

        // Lock loss mid-line, relock inside the same line.
        drive_line(1280, 370, 1'b0, 200, 1);
        drive_line(1280, 370, 1'b1, -1, 0);

        // Async reset while in PREAMBLE.
        for (int i = 0; i < 3; i++) begin
            de_in = 1'b1; rgb_in = 24'($urandom); rand_sync();
            tick();
        end
        chk("lit_in_preamble", 32'(h_ctl), 32'd1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("lit_arst_srst", 32'(h_srst), 32'd1);
        chk("lit_arst_link", 32'(h_link), 32'd0);
        chk("lit_arst_ctl", 32'(h_ctl), 32'd0);
        chk("lit_arst_rgb", 32'(h_rgb), 32'd0);
        chk("lit_arst_err", 32'(h_err), 32'd0);
        de_in = 1'b0;
        tick();
        #1 rst_n = 1'b1;
        idle(40);

        // Randomised lines with short/long blanks and occasional lock drops.
        for (int k = 0; k < 60; k++) begin
            int act, blank, drop_at, drop_len;
            act   = int'($urandom_range(1, 200));
            blank = int'($urandom_range(1, 30));
            drop_at = -1; drop_len = 0;
            if ($urandom_range(0, 5) == 0) begin
                drop_at  = int'($urandom_range(0, 32'(act + blank - 1)));
                drop_len = int'($urandom_range(1, 3));
            end
            drive_line(act, blank, 1'b0, drop_at, drop_len);
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
